dmem_arbiter: RTL and testbench

Arbiter and sequencer for the single-port data memory. It shares the memory between two requesters: port 0 is the CPU load/store stage and port 1 is the test/boot loader. It decodes the MIPS load/store opcode on each request, grants one port at a time with round-robin fairness, runs the memory access, and returns load data with a one-cycle valid pulse. It sits between the decoder/register-file outputs and the data memory, replacing direct opcode-driven memory access with a clocked request/grant protocol.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_sp_ram.sv | 38 +++
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter slice: opcodes, FSM states,
// and default memory geometry.
package dmem_pkg;

  localparam int unsigned DMEM_DEPTH = 64;
  localparam int unsigned DMEM_AW    = 6;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_sp_ram.sv
// Single-port synchronous data RAM: registered read, write-first, no reset.
// Words 0..11 power up holding i+1; all other words power up as zero.
module dmem_sp_ram
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH,
  parameter int unsigned AW    = DMEM_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  typedef logic [31:0] mem_t [DEPTH];

  function automatic mem_t mem_init();
    mem_t m;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      m[i] = (i < 12) ? 32'(i + 1) : '0;
    end
    return m;
  endfunction

  mem_t mem = mem_init();

  // Write-first port: a write also returns the new word on the read output.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-port data memory.
// Port 0 is the CPU load/store stage, port 1 the test/boot loader.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH,
  parameter int unsigned AW    = DMEM_AW
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [5:0]  op0,
  input  logic [5:0]  op1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [1:0]  gnt,
  output logic [1:0]  rvalid,
  output logic [31:0] rdata,
  output logic [1:0]  err,
  output logic        busy
);

  state_t      state, state_nxt;
  logic        last_gnt;
  logic        win;
  logic        pick;
  logic [5:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] hold_q;
  logic [31:0] ram_rd;
  logic [31:0] resp_data;
  logic        in_range;
  logic        is_lw;
  logic        is_sw;
  logic        ram_we;

  // Winner selection: a lone requester wins, a tie goes away from last_gnt.
  always_comb begin
    pick = (req == 2'b11) ? ~last_gnt : req[1];
  end

  // Range and opcode decode of the latched request.
  always_comb begin
    in_range  = (addr_q < 32'(DEPTH));
    is_lw     = (op_q == OP_LW);
    is_sw     = (op_q == OP_SW);
    ram_we    = (state == ACCESS) && is_sw && in_range && rst_n;
    resp_data = in_range ? ram_rd : '0;
  end

  dmem_sp_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (addr_q[AW-1:0]),
    .wdata (wdata_q),
    .rdata (ram_rd)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and Moore-style output pulses.
  always_comb begin
    state_nxt = state;
    gnt       = '0;
    err       = '0;
    rvalid    = '0;
    rdata     = hold_q;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (|req) state_nxt = ACCESS;
      end
      ACCESS: begin
        gnt[win] = 1'b1;
        if (!((is_lw || is_sw) && in_range)) err[win] = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (is_lw) begin
          rvalid[win] = 1'b1;
          rdata       = resp_data;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, round-robin pointer, and held copy of the last load data
  // so rdata stays stable between responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
      win      <= 1'b0;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      hold_q   <= '0;
    end else begin
      if (state == IDLE && |req) begin
        win      <= pick;
        last_gnt <= pick;
        op_q     <= pick ? op1    : op0;
        addr_q   <= pick ? addr1  : addr0;
        wdata_q  <= pick ? wdata1 : wdata0;
      end
      if (state == RESP && is_lw) hold_q <= resp_data;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter.
module tb_dmem_arbiter;

  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [5:0]  op0, op1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  gnt, rvalid, err;
  logic [31:0] rdata;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DEPTH (64),
    .AW    (6)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .op0    (op0),
    .op1    (op1),
    .addr0  (addr0),
    .addr1  (addr1),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .gnt    (gnt),
    .rvalid (rvalid),
    .rdata  (rdata),
    .err    (err),
    .busy   (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for any grant; the caller is positioned 1ns after an edge.
  task automatic wait_gnt(input string tag);
    int n = 0;
    while (gnt == 2'b00 && n < 8) begin
      tick();
      n++;
    end
    check({tag, "_gnt_seen"}, {31'd0, gnt != 2'b00}, 32'd1);
  endtask

  // One single-port transaction, checked through the response cycle.
  task automatic txn(input string tag, input int port, input logic [5:0] op,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] exp_err, input logic [1:0] exp_rv,
                     input logic [31:0] exp_rd);
    logic [1:0] pbit;
    pbit = (port == 1) ? 2'b10 : 2'b01;
    if (port == 1) begin op1 = op; addr1 = a; wdata1 = d; end
    else           begin op0 = op; addr0 = a; wdata0 = d; end
    req = pbit;
    tick();
    wait_gnt(tag);
    check({tag, "_gnt"}, {30'd0, gnt}, {30'd0, pbit});
    check({tag, "_err"}, {30'd0, err}, {30'd0, exp_err});
    req = 2'b00;
    tick();
    check({tag, "_rvalid"}, {30'd0, rvalid}, {30'd0, exp_rv});
    if (exp_rv != 2'b00) check({tag, "_rdata"}, rdata, exp_rd);
    tick();
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b11;
    op0 = LW; op1 = LW; addr0 = 32'd3; addr1 = 32'd0; wdata0 = '0; wdata1 = '0;

    // Reset held with both ports requesting: nothing may happen.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_gnt",    {30'd0, gnt},    32'd0);
      check("rst_rvalid", {30'd0, rvalid}, 32'd0);
      check("rst_err",    {30'd0, err},    32'd0);
      check("rst_busy",   {31'd0, busy},   32'd0);
    end
    rst_n = 1'b1;
    tick();
    check("post_rst_gnt", {30'd0, gnt}, 32'd1);
    req = 2'b00;
    tick();
    check("post_rst_rvalid", {30'd0, rvalid}, 32'd1);
    check("post_rst_rdata", rdata, 32'h4);
    tick();

    // Initial contents, then store/load round trip.
    txn("ld3",   0, LW, 32'd3,  32'd0,         2'b00, 2'b01, 32'h4);
    txn("st20",  1, SW, 32'd20, 32'hDEADBEEF,  2'b00, 2'b00, 32'h0);
    txn("ld20",  0, LW, 32'd20, 32'd0,         2'b00, 2'b01, 32'hDEADBEEF);
    txn("ld11",  1, LW, 32'd11, 32'd0,         2'b00, 2'b10, 32'd12);

    // Reset the round-robin pointer, then hold both ports requesting.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    op0 = LW; addr0 = 32'd1; op1 = LW; addr1 = 32'd7;
    req = 2'b11;
    tick();
    for (int t = 0; t < 4; t++) begin
      logic [1:0]  eg;
      logic [31:0] ed;
      eg = (t % 2 == 0) ? 2'b01 : 2'b10;
      ed = (t % 2 == 0) ? 32'd2 : 32'd8;
      wait_gnt("rr");
      check("rr_gnt", {30'd0, gnt}, {30'd0, eg});
      if (t == 3) req = 2'b00;
      tick();
      check("rr_rvalid", {30'd0, rvalid}, {30'd0, eg});
      check("rr_rdata", rdata, ed);
      tick();
    end
    check("rr_idle", {31'd0, busy}, 32'd0);

    // Error cases.
    txn("st64",  0, SW, 32'd64,        32'hFFFFFFFF, 2'b01, 2'b00, 32'h0);
    txn("ld0",   0, LW, 32'd0,         32'd0,        2'b00, 2'b01, 32'h1);
    txn("ldhi",  1, LW, 32'h80000002,  32'd0,        2'b10, 2'b10, 32'h0);
    txn("badop", 0, 6'b000000, 32'd2,  32'd0,        2'b01, 2'b00, 32'h0);
    txn("ld2",   0, LW, 32'd2,         32'd0,        2'b00, 2'b01, 32'h3);

    // Store whose ACCESS cycle coincides with reset must not land.
    op0 = SW; addr0 = 32'd5; wdata0 = 32'h12345678;
    req = 2'b01;
    tick();
    wait_gnt("rstmid");
    check("rstmid_gnt", {30'd0, gnt}, 32'd1);
    rst_n = 1'b0; req = 2'b00;
    tick();
    check("rstmid_busy",   {31'd0, busy},   32'd0);
    check("rstmid_rvalid", {30'd0, rvalid}, 32'd0);
    rst_n = 1'b1;
    txn("ld5", 0, LW, 32'd5, 32'd0, 2'b00, 2'b01, 32'h6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
